// File: rtl/dac_spi_tx.sv
// dac_spi_tx: one-deep buffered 12-bit SPI frame transmitter for a DAC121S101-class DAC.
// Define DAC_ROUND_EN to round samples to nearest 12-bit code (saturating) instead of truncating.
module dac_spi_tx #(
   parameter int CLK_DIV = 1,
   parameter int GAP_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in_sample,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        dac_sync_n,
   output logic        dac_sclk,
   output logic        dac_sdata,
   output logic        busy,
   output logic        frame_done
);
   localparam int CW = $clog2((CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC) + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [15:0]   shift_q, shift_d;
   logic [11:0]   hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          sync_n_q, sync_n_d;
   logic          sclk_q, sclk_d;
   logic          sdata_q, sdata_d;
   logic          done_q, done_d;
   logic [11:0]   code;
   logic [15:0]   word;
   logic          expire, gap_end, last_fall;
   logic          unused_lsbs;

`ifdef DAC_ROUND_EN
   // A full-scale integer part cannot round up without wrapping, so it is held
   assign code = (&in_sample[15:4]) ? 12'hFFF : in_sample[15:4] + {11'd0, in_sample[3]};
`else
   assign code = in_sample[15:4];
`endif

   assign unused_lsbs = ^in_sample[3:0];
   assign word        = {4'b0000, hold_q};
   assign expire      = cnt_q == CW'(CLK_DIV - 1);
   assign gap_end     = cnt_q == CW'(GAP_CYC - 1);
   assign last_fall   = expire && !sclk_q && bit_q == 4'd15;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         sync_n_q    <= 1'b1;
         sclk_q      <= 1'b1;
         sdata_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         sync_n_q    <= sync_n_d;
         sclk_q      <= sclk_d;
         sdata_q     <= sdata_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && hold_full_q) state_d = SHIFT;
      else if (state_q == SHIFT && last_fall) state_d = GAP;
      else if (state_q == GAP && gap_end) state_d = IDLE;
   end

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_d       = bit_q;
      cnt_d       = cnt_q;
      sync_n_d    = sync_n_q;
      sclk_d      = sclk_q;
      sdata_d     = sdata_q;
      done_d      = 1'b0;
      if (in_valid && !hold_full_q) begin
         hold_d      = code;
         hold_full_d = 1'b1;
      end
      if (state_q == IDLE && hold_full_q) begin
         shift_d     = word;
         sdata_d     = word[15];
         hold_full_d = 1'b0;
         sync_n_d    = 1'b0;
         sclk_d      = 1'b1;
         bit_d       = '0;
         cnt_d       = '0;
      end else if (state_q == SHIFT) begin
         cnt_d = expire ? '0 : cnt_q + CW'(1);
         if (expire) sclk_d = !sclk_q;
         // Next bit is presented on the rising edge, away from the DAC's falling-edge sample
         if (expire && !sclk_q && bit_q != 4'd15) begin
            shift_d = {shift_q[14:0], 1'b0};
            sdata_d = shift_q[14];
            bit_d   = bit_q + 4'd1;
         end
         if (last_fall) begin
            done_d   = 1'b1;
            sync_n_d = 1'b1;
            sdata_d  = 1'b0;
         end
      end else if (state_q == GAP) begin
         cnt_d = gap_end ? '0 : cnt_q + CW'(1);
      end
   end

   assign in_ready   = !hold_full_q;
   assign dac_sync_n = sync_n_q;
   assign dac_sclk   = sclk_q;
   assign dac_sdata  = sdata_q;
   assign busy       = state_q != IDLE;
   assign frame_done = done_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed checks of dac_spi_tx framing, buffering and reset with CLK_DIV=1 and CLK_DIV=3.
module tb_dac_spi_tx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a_in_sample = '0, b_in_sample = '0;
   logic        a_in_valid = 1'b0, b_in_valid = 1'b0;
   logic        a_in_ready, a_sync_n, a_sclk, a_sdata, a_busy, a_done;
   logic        b_in_ready, b_sync_n, b_sclk, b_sdata, b_busy, b_done;
   logic        sel = 1'b0;
   logic        m_ready, m_sync, m_sclk, m_sdata, m_busy, m_done;
   int          vectors = 0, miscompares = 0, cyc = 0;
   logic [15:0] cap_word;
   int          cap_low, cap_done, cap_busy, cap_hmin, cap_hmax, cap_start;
   logic        cap_to;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dac_spi_tx #(.CLK_DIV(1), .GAP_CYC(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_sample(a_in_sample), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .dac_sync_n(a_sync_n), .dac_sclk(a_sclk),
      .dac_sdata(a_sdata), .busy(a_busy), .frame_done(a_done));

   dac_spi_tx #(.CLK_DIV(3), .GAP_CYC(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_sample(b_in_sample), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .dac_sync_n(b_sync_n), .dac_sclk(b_sclk),
      .dac_sdata(b_sdata), .busy(b_busy), .frame_done(b_done));

   assign m_ready = sel ? b_in_ready : a_in_ready;
   assign m_sync  = sel ? b_sync_n   : a_sync_n;
   assign m_sclk  = sel ? b_sclk     : a_sclk;
   assign m_sdata = sel ? b_sdata    : a_sdata;
   assign m_busy  = sel ? b_busy     : a_busy;
   assign m_done  = sel ? b_done     : a_done;

   task automatic feed(input logic [15:0] v);
      logic acc;
      if (sel) begin b_in_sample = v; b_in_valid = 1'b1; end
      else begin a_in_sample = v; a_in_valid = 1'b1; end
      for (int i = 0; i < 200; i++) begin
         acc = m_ready;
         @(negedge clk);
         if (acc) break;
      end
      if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
   endtask

   // Records one frame: bits at SCLK falls, SYNC low length, half-periods, done pulses, busy tail
   task automatic capture(input int bound);
      logic prev;
      int   last, i;
      cap_to = 1'b0; cap_word = '0; cap_low = 0; cap_done = 0; cap_busy = 0;
      cap_hmin = 1000; cap_hmax = 0;
      i = 0;
      while (m_sync !== 1'b0 && i < bound) begin @(negedge clk); i++; end
      if (m_sync !== 1'b0) begin cap_to = 1'b1; return; end
      cap_start = cyc; prev = 1'b1; last = 0;
      while (m_sync === 1'b0 && cap_low < 2000) begin
         if (m_sclk !== prev) begin
            if (cap_low - last < cap_hmin) cap_hmin = cap_low - last;
            if (cap_low - last > cap_hmax) cap_hmax = cap_low - last;
            last = cap_low;
            if (prev === 1'b1) cap_word = {cap_word[14:0], m_sdata};
            prev = m_sclk;
         end
         cap_done += int'(m_done);
         cap_low++;
         @(negedge clk);
      end
      i = 0;
      while (m_busy !== 1'b0 && i < 50) begin cap_done += int'(m_done); i++; @(negedge clk); end
      cap_busy = i;
   endtask

   task automatic test_reset;
      vectors += 6;
      if (a_sync_n !== 1'b1) begin miscompares++; $display("FAIL reset_sync_n got %b want 1", a_sync_n); end
      if (a_sclk !== 1'b1) begin miscompares++; $display("FAIL reset_sclk got %b want 1", a_sclk); end
      if (a_sdata !== 1'b0) begin miscompares++; $display("FAIL reset_sdata got %b want 0", a_sdata); end
      if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", a_busy); end
      if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b want 0", a_done); end
      if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
   endtask

   task automatic test_frame;
      sel = 1'b0;
      feed(16'hABCD);
      vectors++;
      if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL frame_ready_after_accept got %b want 0", a_in_ready); end
      capture(20);
      vectors += 7;
      if (cap_to !== 1'b0) begin miscompares++; $display("FAIL frame_timeout got %b want 0", cap_to); end
      if (cap_word !== 16'h0ABC) begin miscompares++; $display("FAIL frame_word got %h want 0abc", cap_word); end
      if (cap_low !== 32) begin miscompares++; $display("FAIL frame_sync_low got %0d want 32", cap_low); end
      if (cap_done !== 1) begin miscompares++; $display("FAIL frame_done_count got %0d want 1", cap_done); end
      if (cap_busy !== 2) begin miscompares++; $display("FAIL frame_busy_tail got %0d want 2", cap_busy); end
      if (cap_hmin !== 1) begin miscompares++; $display("FAIL frame_half_min got %0d want 1", cap_hmin); end
      if (cap_hmax !== 1) begin miscompares++; $display("FAIL frame_half_max got %0d want 1", cap_hmax); end
   endtask

   task automatic test_rounding;
      logic [15:0] exp_abc8;
`ifdef DAC_ROUND_EN
      exp_abc8 = 16'h0ABD;
`else
      exp_abc8 = 16'h0ABC;
`endif
      sel = 1'b0;
      feed(16'hABC8);
      capture(20);
      vectors++;
      if (cap_word !== exp_abc8) begin miscompares++; $display("FAIL round_abc8 got %h want %h", cap_word, exp_abc8); end
      feed(16'hFFFF);
      capture(20);
      vectors++;
      if (cap_word !== 16'h0FFF) begin miscompares++; $display("FAIL round_ffff_sat got %h want 0fff", cap_word); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] w [3];
      int          st [3];
      int          rbad;
      sel = 1'b0;
      rbad = 0;
      fork
         begin
            feed(16'h1230); if (a_in_ready !== 1'b0) rbad++;
            feed(16'h4560); if (a_in_ready !== 1'b0) rbad++;
            feed(16'h7890); if (a_in_ready !== 1'b0) rbad++;
         end
         begin
            for (int k = 0; k < 3; k++) begin capture(100); w[k] = cap_word; st[k] = cap_start; end
         end
      join
      vectors += 6;
      if (rbad !== 0) begin miscompares++; $display("FAIL b2b_ready_while_full got %0d highs want 0", rbad); end
      if (w[0] !== 16'h0123) begin miscompares++; $display("FAIL b2b_word0 got %h want 0123", w[0]); end
      if (w[1] !== 16'h0456) begin miscompares++; $display("FAIL b2b_word1 got %h want 0456", w[1]); end
      if (w[2] !== 16'h0789) begin miscompares++; $display("FAIL b2b_word2 got %h want 0789", w[2]); end
      if (st[1] - st[0] !== 35) begin miscompares++; $display("FAIL b2b_period01 got %0d want 35", st[1] - st[0]); end
      if (st[2] - st[1] !== 35) begin miscompares++; $display("FAIL b2b_period12 got %0d want 35", st[2] - st[1]); end
   endtask

   task automatic test_buffer_full;
      logic [15:0] w1, w2;
      int          rbad;
      sel = 1'b0;
      rbad = 0;
      fork
         begin
            feed(16'h5550);
            feed(16'h1110);
            a_in_sample = 16'h2220; a_in_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin if (a_in_ready !== 1'b0) rbad++; @(negedge clk); end
            a_in_valid = 1'b0;
         end
         begin
            capture(20); w1 = cap_word;
            capture(100); w2 = cap_word;
         end
      join
      vectors += 3;
      if (rbad !== 0) begin miscompares++; $display("FAIL full_ready got %0d highs want 0", rbad); end
      if (w1 !== 16'h0555) begin miscompares++; $display("FAIL full_word1 got %h want 0555", w1); end
      if (w2 !== 16'h0111) begin miscompares++; $display("FAIL full_word2 got %h want 0111", w2); end
      capture(60);
      vectors++;
      if (cap_to !== 1'b1) begin miscompares++; $display("FAIL full_no_third_frame got word %h want none", cap_word); end
   endtask

   task automatic test_reset_mid_frame;
      logic prev;
      int   falls, spur;
      sel = 1'b0;
      feed(16'h8880);
      prev = 1'b1; falls = 0;
      for (int i = 0; i < 40 && falls < 5; i++) begin
         @(negedge clk);
         if (prev === 1'b1 && a_sclk === 1'b0) falls++;
         prev = a_sclk;
      end
      vectors += 6;
      if (a_sync_n !== 1'b0) begin miscompares++; $display("FAIL midrst_pre_sync got %b want 0", a_sync_n); end
      #2 rst_n = 1'b0;
      #1;
      if (a_sync_n !== 1'b1) begin miscompares++; $display("FAIL midrst_sync got %b want 1", a_sync_n); end
      if (a_sclk !== 1'b1) begin miscompares++; $display("FAIL midrst_sclk got %b want 1", a_sclk); end
      if (a_sdata !== 1'b0) begin miscompares++; $display("FAIL midrst_sdata got %b want 0", a_sdata); end
      if (a_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", a_busy); end
      if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", a_in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      spur = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (a_sync_n !== 1'b1 || a_busy !== 1'b0 || a_sclk !== 1'b1) spur++;
      end
      vectors++;
      if (spur !== 0) begin miscompares++; $display("FAIL midrst_spurious got %0d active cycles want 0", spur); end
   endtask

   task automatic test_clk_div3;
      sel = 1'b1;
      feed(16'h8000);
      capture(20);
      vectors += 6;
      if (cap_to !== 1'b0) begin miscompares++; $display("FAIL div3_timeout got %b want 0", cap_to); end
      if (cap_word !== 16'h0800) begin miscompares++; $display("FAIL div3_word got %h want 0800", cap_word); end
      if (cap_low !== 96) begin miscompares++; $display("FAIL div3_sync_low got %0d want 96", cap_low); end
      if (cap_hmin !== 3) begin miscompares++; $display("FAIL div3_half_min got %0d want 3", cap_hmin); end
      if (cap_hmax !== 3) begin miscompares++; $display("FAIL div3_half_max got %0d want 3", cap_hmax); end
      if (cap_done !== 1) begin miscompares++; $display("FAIL div3_done_count got %0d want 1", cap_done); end
      sel = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      test_frame;
      test_rounding;
      test_back_to_back;
      test_buffer_full;
      test_reset_mid_frame;
      test_clk_div3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
